// File: rtl/allocate_operand_fetch.sv
// Operand-fetch stage: reads both register-file ports, bypasses same-cycle
// writeback data and holds one instruction in the issue register for dispatch.
module allocate_operand_fetch #(
    parameter int PAYLOAD_W = 32
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFLUSH,
    input  logic                 iPREV_VALID,
    output logic                 oPREV_LOCK,
    input  logic                 iPREV_SRC0_USE,
    input  logic                 iPREV_SRC1_USE,
    input  logic [4:0]           iPREV_SRC0,
    input  logic [4:0]           iPREV_SRC1,
    input  logic                 iPREV_DEST_WR,
    input  logic [4:0]           iPREV_DEST,
    input  logic [PAYLOAD_W-1:0] iPREV_PAYLOAD,
    output logic [4:0]           oRF_RD0_ADDR,
    output logic [4:0]           oRF_RD1_ADDR,
    input  logic [31:0]          iRF_RD0_DATA,
    input  logic [31:0]          iRF_RD1_DATA,
    input  logic                 iWB_VALID,
    input  logic [4:0]           iWB_ADDR,
    input  logic [31:0]          iWB_DATA,
    output logic                 oNEXT_VALID,
    input  logic                 iNEXT_LOCK,
    output logic [31:0]          oNEXT_SRC0_DATA,
    output logic [31:0]          oNEXT_SRC1_DATA,
    output logic                 oNEXT_DEST_WR,
    output logic [4:0]           oNEXT_DEST,
    output logic [PAYLOAD_W-1:0] oNEXT_PAYLOAD,
    output logic [31:0]          oSTALL_COUNT
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_t;

    issue_state_t         state_r;
    logic [31:0]          sb_r;
    logic [31:0]          src0_data_r;
    logic [31:0]          src1_data_r;
    logic                 dest_wr_r;
    logic [4:0]           dest_r;
    logic [PAYLOAD_W-1:0] payload_r;
    logic [31:0]          stall_cnt_r;

    logic                 srst_s;
    logic                 wbhit_src0_s;
    logic                 wbhit_src1_s;
    logic                 wbhit_dest_s;
    logic                 pend_src0_s;
    logic                 pend_src1_s;
    logic                 pend_dest_s;
    logic                 raw_s;
    logic                 waw_s;
    logic                 hold_s;
    logic                 lock_s;
    logic                 accept_s;
    logic                 stall_inc_s;
    logic [31:0]          src0_sel_s;
    logic [31:0]          src1_sel_s;
    logic [31:0]          sb_clr_mask_s;
    logic [31:0]          sb_set_mask_s;
    logic [31:0]          sb_next_s;

    // Flush acts as the synchronous soft reset of the issue slot and scoreboard.
    assign srst_s = iFLUSH;

    assign oRF_RD0_ADDR = iPREV_SRC0;
    assign oRF_RD1_ADDR = iPREV_SRC1;

    // Hazard detection; a register being written back this cycle is no longer pending.
    always_comb begin
        wbhit_src0_s = iWB_VALID && (iWB_ADDR == iPREV_SRC0);
        wbhit_src1_s = iWB_VALID && (iWB_ADDR == iPREV_SRC1);
        wbhit_dest_s = iWB_VALID && (iWB_ADDR == iPREV_DEST);
        pend_src0_s  = sb_r[iPREV_SRC0] && !wbhit_src0_s;
        pend_src1_s  = sb_r[iPREV_SRC1] && !wbhit_src1_s;
        pend_dest_s  = sb_r[iPREV_DEST] && !wbhit_dest_s;
        raw_s        = (iPREV_SRC0_USE && pend_src0_s) || (iPREV_SRC1_USE && pend_src1_s);
        waw_s        = iPREV_DEST_WR && pend_dest_s;
        hold_s       = (state_r == ST_FULL) && iNEXT_LOCK;
        lock_s       = raw_s || waw_s || hold_s;
        accept_s     = iPREV_VALID && !lock_s && !srst_s;
        stall_inc_s  = iPREV_VALID && (raw_s || waw_s) && !hold_s;
    end

    assign oPREV_LOCK = lock_s;

    // Operand select: the register file only updates at the edge, so bypass wins.
    always_comb begin
        if (wbhit_src0_s) begin
            src0_sel_s = iWB_DATA;
        end else begin
            src0_sel_s = iRF_RD0_DATA;
        end
        if (wbhit_src1_s) begin
            src1_sel_s = iWB_DATA;
        end else begin
            src1_sel_s = iRF_RD1_DATA;
        end
    end

    // Scoreboard next state; a new destination set beats a same-cycle clear.
    always_comb begin
        if (iWB_VALID) begin
            sb_clr_mask_s = 32'h0000_0001 << iWB_ADDR;
        end else begin
            sb_clr_mask_s = 32'h0000_0000;
        end
        if (accept_s && iPREV_DEST_WR) begin
            sb_set_mask_s = 32'h0000_0001 << iPREV_DEST;
        end else begin
            sb_set_mask_s = 32'h0000_0000;
        end
        if (srst_s) begin
            sb_next_s = 32'h0000_0000;
        end else begin
            sb_next_s = (sb_r & ~sb_clr_mask_s) | sb_set_mask_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            sb_r <= 32'h0000_0000;
        end else begin
            sb_r <= sb_next_s;
        end
    end

    // Issue slot occupancy: EMPTY/FULL with flush forcing EMPTY.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r <= ST_FULL;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (srst_s) begin
                        state_r <= ST_EMPTY;
                    end else if (accept_s || hold_s) begin
                        state_r <= ST_FULL;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Issue data fields load only on accept and otherwise keep their value.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            src0_data_r <= 32'h0000_0000;
            src1_data_r <= 32'h0000_0000;
            dest_wr_r   <= 1'b0;
            dest_r      <= 5'd0;
            payload_r   <= {PAYLOAD_W{1'b0}};
        end else if (accept_s) begin
            src0_data_r <= src0_sel_s;
            src1_data_r <= src1_sel_s;
            dest_wr_r   <= iPREV_DEST_WR;
            dest_r      <= iPREV_DEST;
            payload_r   <= iPREV_PAYLOAD;
        end else begin
            src0_data_r <= src0_data_r;
            src1_data_r <= src1_data_r;
            dest_wr_r   <= dest_wr_r;
            dest_r      <= dest_r;
            payload_r   <= payload_r;
        end
    end

    // Saturating hazard-stall counter; survives flush, cleared only by reset.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (stall_inc_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign oNEXT_VALID     = (state_r == ST_FULL);
    assign oNEXT_SRC0_DATA = src0_data_r;
    assign oNEXT_SRC1_DATA = src1_data_r;
    assign oNEXT_DEST_WR   = dest_wr_r;
    assign oNEXT_DEST      = dest_r;
    assign oNEXT_PAYLOAD   = payload_r;
    assign oSTALL_COUNT    = stall_cnt_r;

endmodule

// File: tb/tb_allocate_operand_fetch.sv
// Bench for allocate_operand_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_allocate_operand_fetch;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iFLUSH;
    logic        iPREV_VALID;
    logic        oPREV_LOCK;
    logic        iPREV_SRC0_USE;
    logic        iPREV_SRC1_USE;
    logic [4:0]  iPREV_SRC0;
    logic [4:0]  iPREV_SRC1;
    logic        iPREV_DEST_WR;
    logic [4:0]  iPREV_DEST;
    logic [31:0] iPREV_PAYLOAD;
    logic [4:0]  oRF_RD0_ADDR;
    logic [4:0]  oRF_RD1_ADDR;
    logic [31:0] iRF_RD0_DATA;
    logic [31:0] iRF_RD1_DATA;
    logic        iWB_VALID;
    logic [4:0]  iWB_ADDR;
    logic [31:0] iWB_DATA;
    logic        oNEXT_VALID;
    logic        iNEXT_LOCK;
    logic [31:0] oNEXT_SRC0_DATA;
    logic [31:0] oNEXT_SRC1_DATA;
    logic        oNEXT_DEST_WR;
    logic [4:0]  oNEXT_DEST;
    logic [31:0] oNEXT_PAYLOAD;
    logic [31:0] oSTALL_COUNT;

    allocate_operand_fetch #(.PAYLOAD_W(32)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iFLUSH(iFLUSH),
        .iPREV_VALID(iPREV_VALID), .oPREV_LOCK(oPREV_LOCK),
        .iPREV_SRC0_USE(iPREV_SRC0_USE), .iPREV_SRC1_USE(iPREV_SRC1_USE),
        .iPREV_SRC0(iPREV_SRC0), .iPREV_SRC1(iPREV_SRC1),
        .iPREV_DEST_WR(iPREV_DEST_WR), .iPREV_DEST(iPREV_DEST),
        .iPREV_PAYLOAD(iPREV_PAYLOAD),
        .oRF_RD0_ADDR(oRF_RD0_ADDR), .oRF_RD1_ADDR(oRF_RD1_ADDR),
        .iRF_RD0_DATA(iRF_RD0_DATA), .iRF_RD1_DATA(iRF_RD1_DATA),
        .iWB_VALID(iWB_VALID), .iWB_ADDR(iWB_ADDR), .iWB_DATA(iWB_DATA),
        .oNEXT_VALID(oNEXT_VALID), .iNEXT_LOCK(iNEXT_LOCK),
        .oNEXT_SRC0_DATA(oNEXT_SRC0_DATA), .oNEXT_SRC1_DATA(oNEXT_SRC1_DATA),
        .oNEXT_DEST_WR(oNEXT_DEST_WR), .oNEXT_DEST(oNEXT_DEST),
        .oNEXT_PAYLOAD(oNEXT_PAYLOAD), .oSTALL_COUNT(oSTALL_COUNT)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Bench-owned register file, written by the same writeback the DUT sees.
    logic [31:0] rf [32];
    assign iRF_RD0_DATA = rf[oRF_RD0_ADDR];
    assign iRF_RD1_DATA = rf[oRF_RD1_ADDR];
    always @(posedge iCLOCK) if (iWB_VALID) rf[iWB_ADDR] <= iWB_DATA;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: set of pending registers plus the expected issue slot.
    bit          pend_m [32];
    bit          m_valid;
    logic [31:0] m_src0, m_src1, m_payload, m_stall;
    bit          m_dest_wr;
    logic [4:0]  m_dest;

    function automatic bit m_hit(input logic [4:0] r);
        return iWB_VALID && (iWB_ADDR == r);
    endfunction
    function automatic bit m_pend(input logic [4:0] r);
        return pend_m[r] && !m_hit(r);
    endfunction
    function automatic bit m_hazard();
        return (iPREV_SRC0_USE && m_pend(iPREV_SRC0)) || (iPREV_SRC1_USE && m_pend(iPREV_SRC1))
            || (iPREV_DEST_WR && m_pend(iPREV_DEST));
    endfunction
    function automatic bit m_hold();
        return m_valid && iNEXT_LOCK;
    endfunction

    always @(posedge iCLOCK or negedge inRESET) begin
        bit hz, hd, acc;
        if (!inRESET) begin
            for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
            m_valid = 1'b0; m_src0 = 32'h0; m_src1 = 32'h0; m_payload = 32'h0;
            m_dest_wr = 1'b0; m_dest = 5'd0; m_stall = 32'h0;
        end else begin
            hz  = m_hazard();
            hd  = m_hold();
            acc = iPREV_VALID && !hz && !hd && !iFLUSH;
            if (iPREV_VALID && hz && !hd && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'h1;
            if (acc) begin
                m_src0    = m_hit(iPREV_SRC0) ? iWB_DATA : rf[iPREV_SRC0];
                m_src1    = m_hit(iPREV_SRC1) ? iWB_DATA : rf[iPREV_SRC1];
                m_dest_wr = iPREV_DEST_WR;
                m_dest    = iPREV_DEST;
                m_payload = iPREV_PAYLOAD;
                m_valid   = 1'b1;
            end else if (iFLUSH || !hd) begin
                m_valid = 1'b0;
            end
            if (iFLUSH) begin
                for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
            end else begin
                if (iWB_VALID) pend_m[iWB_ADDR] = 1'b0;
                if (acc && iPREV_DEST_WR) pend_m[iPREV_DEST] = 1'b1;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge iCLOCK) begin
        if (cmp_en) begin
            check("m_lock",  {31'h0, oPREV_LOCK}, {31'h0, (m_hazard() || m_hold())});
            check("m_rd0",   {27'h0, oRF_RD0_ADDR}, {27'h0, iPREV_SRC0});
            check("m_rd1",   {27'h0, oRF_RD1_ADDR}, {27'h0, iPREV_SRC1});
            check("m_valid", {31'h0, oNEXT_VALID}, {31'h0, m_valid});
            check("m_src0",  oNEXT_SRC0_DATA, m_src0);
            check("m_src1",  oNEXT_SRC1_DATA, m_src1);
            check("m_dwr",   {31'h0, oNEXT_DEST_WR}, {31'h0, m_dest_wr});
            check("m_dest",  {27'h0, oNEXT_DEST}, {27'h0, m_dest});
            check("m_pay",   oNEXT_PAYLOAD, m_payload);
            check("m_stall", oSTALL_COUNT, m_stall);
        end
    end

    task automatic tick();
        @(posedge iCLOCK);
        #2;
    endtask

    task automatic idle();
        iPREV_VALID = 1'b0; iPREV_SRC0_USE = 1'b0; iPREV_SRC1_USE = 1'b0;
        iPREV_SRC0 = 5'd0; iPREV_SRC1 = 5'd0; iPREV_DEST_WR = 1'b0; iPREV_DEST = 5'd0;
        iPREV_PAYLOAD = 32'h0;
    endtask

    task automatic drive(input bit u0, input logic [4:0] s0, input bit u1, input logic [4:0] s1,
                         input bit dw, input logic [4:0] d, input logic [31:0] pay);
        iPREV_VALID = 1'b1; iPREV_SRC0_USE = u0; iPREV_SRC0 = s0; iPREV_SRC1_USE = u1;
        iPREV_SRC1 = s1; iPREV_DEST_WR = dw; iPREV_DEST = d; iPREV_PAYLOAD = pay;
    endtask

    task automatic wb(input bit v, input logic [4:0] a, input logic [31:0] d);
        iWB_VALID = v; iWB_ADDR = a; iWB_DATA = d;
    endtask

    initial begin
        logic [4:0] plist [$];
        inRESET = 1'b0; iFLUSH = 1'b0; iNEXT_LOCK = 1'b0;
        idle();
        wb(1'b0, 5'd0, 32'h0);
        tick();
        // Preload the register file during reset; r3/r4 carry the known values.
        for (int r = 0; r < 32; r++) begin
            wb(1'b1, r[4:0], (r == 3) ? 32'h11 : (r == 4) ? 32'h22 : $urandom);
            tick();
        end
        wb(1'b0, 5'd0, 32'h0);
        cmp_en = 1'b1;
        check("rst_valid", {31'h0, oNEXT_VALID}, 32'h0);
        check("rst_stall", oSTALL_COUNT, 32'h0);
        check("rst_src0",  oNEXT_SRC0_DATA, 32'h0);
        check("rst_lock",  {31'h0, oPREV_LOCK}, 32'h0);
        inRESET = 1'b1;
        tick();

        // Basic issue with both operands from the register file.
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 32'hA1);
        #1 check("t1_lock", {31'h0, oPREV_LOCK}, 32'h0);
        tick();
        check("t1_valid", {31'h0, oNEXT_VALID}, 32'h1);
        check("t1_src0", oNEXT_SRC0_DATA, 32'h11);
        check("t1_src1", oNEXT_SRC1_DATA, 32'h22);
        idle();

        // RAW on r5, resolved by a bypassed writeback.
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hB1);
        tick();
        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'hB2);
        #1 check("raw_lock", {31'h0, oPREV_LOCK}, 32'h1);
        tick();
        check("raw_stall1", oSTALL_COUNT, 32'd1);
        tick();
        check("raw_stall2", oSTALL_COUNT, 32'd2);
        wb(1'b1, 5'd5, 32'hDEAD);
        #1 check("raw_wb_lock", {31'h0, oPREV_LOCK}, 32'h0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("raw_src0", oNEXT_SRC0_DATA, 32'hDEAD);
        check("raw_pay", oNEXT_PAYLOAD, 32'hB2);
        check("raw_stall3", oSTALL_COUNT, 32'd2);
        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'hB3);
        #1 check("raw_sb_clr", {31'h0, oPREV_LOCK}, 32'h0);
        tick();
        idle();

        // WAW on r7; second writer accepted in the writeback cycle keeps r7 pending.
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hC1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hC2);
        #1 check("waw_lock", {31'h0, oPREV_LOCK}, 32'h1);
        tick();
        wb(1'b1, 5'd7, 32'h77);
        #1 check("waw_wb_lock", {31'h0, oPREV_LOCK}, 32'h0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("waw_dest", {27'h0, oNEXT_DEST}, 32'd7);
        check("waw_pay", oNEXT_PAYLOAD, 32'hC2);
        check("waw_stall", oSTALL_COUNT, 32'd3);
        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'hC3);
        #1 check("waw_sb_set", {31'h0, oPREV_LOCK}, 32'h1);
        idle();
        wb(1'b1, 5'd7, 32'h78);
        tick();
        wb(1'b0, 5'd0, 32'h0);

        // Downstream hold for three cycles.
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'hD1);
        tick();
        iNEXT_LOCK = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'hD2);
        #1 check("hold_lock", {31'h0, oPREV_LOCK}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_pay", oNEXT_PAYLOAD, 32'hD1);
            check("hold_valid", {31'h0, oNEXT_VALID}, 32'h1);
            check("hold_stall", oSTALL_COUNT, 32'd3);
        end
        iNEXT_LOCK = 1'b0;
        #1 check("rel_lock", {31'h0, oPREV_LOCK}, 32'h0);
        tick();
        check("rel_pay", oNEXT_PAYLOAD, 32'hD2);
        idle();

        // Flush with r9/r10 pending.
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hE1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 32'hE2);
        tick();
        iFLUSH = 1'b1;
        drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'hE3);
        #1 check("fl_lock", {31'h0, oPREV_LOCK}, 32'h1);
        tick();
        iFLUSH = 1'b0;
        check("fl_valid", {31'h0, oNEXT_VALID}, 32'h0);
        check("fl_stall", oSTALL_COUNT, 32'd4);
        #1 check("fl_nolock", {31'h0, oPREV_LOCK}, 32'h0);
        tick();
        check("fl_issue", oNEXT_PAYLOAD, 32'hE3);
        idle();

        // Asynchronous reset in the middle of a stall.
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'hF1);
        tick();
        drive(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 32'hF2);
        tick();
        tick();
        check("ar_stall", oSTALL_COUNT, 32'd6);
        #1 inRESET = 1'b0;
        #1 check("ar_valid", {31'h0, oNEXT_VALID}, 32'h0);
        check("ar_cnt", oSTALL_COUNT, 32'h0);
        tick();
        inRESET = 1'b1;
        #1 check("ar_lock", {31'h0, oPREV_LOCK}, 32'h0);
        tick();
        check("ar_issue", oNEXT_PAYLOAD, 32'hF2);
        idle();

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            iPREV_VALID    = ($urandom_range(0, 9) < 7);
            iPREV_SRC0_USE = $urandom_range(0, 1);
            iPREV_SRC1_USE = $urandom_range(0, 1);
            iPREV_SRC0     = 5'($urandom_range(0, 7));
            iPREV_SRC1     = 5'($urandom_range(0, 7));
            iPREV_DEST_WR  = ($urandom_range(0, 9) < 6);
            iPREV_DEST     = 5'($urandom_range(0, 7));
            iPREV_PAYLOAD  = $urandom;
            iNEXT_LOCK     = ($urandom_range(0, 3) == 0);
            iFLUSH         = ($urandom_range(0, 49) == 0);
            plist.delete();
            for (int r = 0; r < 32; r++) if (pend_m[r]) plist.push_back(5'(r));
            if ($urandom_range(0, 1) == 1) begin
                if (plist.size() > 0 && $urandom_range(0, 4) != 0)
                    wb(1'b1, plist[$urandom_range(0, plist.size() - 1)], $urandom);
                else
                    wb(1'b1, 5'($urandom_range(0, 7)), $urandom);
            end else begin
                wb(1'b0, 5'd0, 32'h0);
            end
            tick();
        end
        idle();
        iFLUSH = 1'b0; iNEXT_LOCK = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/allocate_operand_fetch.md
Name: allocate_operand_fetch

Overview:
- Operand-fetch stage directly downstream of the two-read-port general register file in the allocate stage.
- Drives the register-file read addresses and captures both source operands into the issue register.
- Tracks in-flight destination writes with a 32-entry scoreboard and bypasses same-cycle writeback data.
- Stalls decode on RAW/WAW hazards or downstream back-pressure; hands one instruction per cycle to dispatch.

Parameters:
- PAYLOAD_W, 32, width of opaque instruction payload carried alongside operands.

Ports:
- iCLOCK  in  1  clock, all state on rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iFLUSH  in  1  synchronous pipeline flush.
- iPREV_VALID  in  1  decode presents an instruction.
- oPREV_LOCK  out  1  stall to decode; instruction not accepted while high.
- iPREV_SRC0_USE / iPREV_SRC1_USE  in  1 each  source operand used.
- iPREV_SRC0 / iPREV_SRC1  in  5 each  source register numbers.
- iPREV_DEST_WR  in  1  instruction writes a register.
- iPREV_DEST  in  5  destination register number.
- iPREV_PAYLOAD  in  PAYLOAD_W  passthrough.
- oRF_RD0_ADDR / oRF_RD1_ADDR  out  5 each  register-file read addresses (combinational from iPREV_SRC0/1).
- iRF_RD0_DATA / iRF_RD1_DATA  in  32 each  register-file read data, same-cycle.
- iWB_VALID  in  1  writeback this cycle (same signal that writes the register file).
- iWB_ADDR  in  5  writeback register.
- iWB_DATA  in  32  writeback data.
- oNEXT_VALID  out  1  issue register valid.
- iNEXT_LOCK  in  1  dispatch back-pressure.
- oNEXT_SRC0_DATA / oNEXT_SRC1_DATA  out  32 each  operands.
- oNEXT_DEST_WR  out  1.
- oNEXT_DEST  out  5.
- oNEXT_PAYLOAD  out  PAYLOAD_W.
- oSTALL_COUNT  out  32  saturating count of hazard-stall cycles.

Behaviour:
- Reset (inRESET=0, async): oNEXT_VALID=0, all oNEXT_* data outputs=0, scoreboard=0, oSTALL_COUNT=0. oPREV_LOCK follows the combinational equation, which evaluates to 0 after reset.
- Hazard terms, each combinational:
  - wbhit(r) = iWB_VALID && iWB_ADDR==r.
  - pend(r) = sb[r] && !wbhit(r).
  - raw = (SRC0_USE && pend(SRC0)) || (SRC1_USE && pend(SRC1)).
  - waw = DEST_WR && pend(DEST).
  - hold = oNEXT_VALID && iNEXT_LOCK.
- oPREV_LOCK = raw || waw || hold.
- accept = iPREV_VALID && !oPREV_LOCK.
- Latency: accepted in cycle N, oNEXT_VALID=1 with operands in cycle N+1.
- Operand select per source: wbhit ? iWB_DATA : iRF_RDx_DATA. Bypass has priority because the register file updates only at the edge. Unused sources still latch the selected value.
- Issue register:
  - accept: load all fields and set oNEXT_VALID=1.
  - hold: keep all fields.
  - otherwise: clear oNEXT_VALID (data fields keep their value).
- Scoreboard, 32 bits:
  - wb clears sb[iWB_ADDR].
  - accept && DEST_WR sets sb[DEST].
  - Same register both events in one cycle: set wins.
  - Only one destination is pending per register at a time, because WAW stalls.
- oSTALL_COUNT increments when iPREV_VALID && (raw || waw) && !hold. Saturates at 0xFFFF_FFFF. Not cleared by flush.
- iFLUSH: next edge clears oNEXT_VALID and the whole scoreboard. The current decode instruction is not accepted. oPREV_LOCK ignores flush. Downstream suppresses writebacks of flushed instructions. A writeback arriving with flush is dropped from scoreboard handling; the register-file write is unaffected.
- Reset mid-stall: all state cleared immediately, with no partial issue.
- Structurally this is two states, EMPTY and FULL (oNEXT_VALID). FULL→FULL occurs on accept or hold, FULL→EMPTY when not holding and not accepting, EMPTY→FULL on accept.

Test Plan:
- Reset, then issue SRC0=3, SRC1=4 with RF returning 0x11/0x22, no writeback -> next cycle oNEXT_VALID=1, SRC0_DATA=0x11, SRC1_DATA=0x22, oPREV_LOCK=0.
- Issue DEST_WR r5, then next instruction with SRC0=r5 -> oPREV_LOCK=1 and oSTALL_COUNT increments each cycle. Writeback r5=0xDEAD arrives -> accepted that same cycle with SRC0_DATA=0xDEAD, and sb[5]=0 afterwards.
- WAW: two back-to-back DEST_WR r7 -> second stalls until writeback r7. If the second instruction is accepted in the writeback cycle, sb[7] is left =1.
- Hold iNEXT_LOCK=1 for 3 cycles with oNEXT_VALID=1 -> outputs stable, oPREV_LOCK=1, oSTALL_COUNT unchanged. Release -> next instruction issues one cycle later.
- Pending r9 and r10, then assert iFLUSH -> oNEXT_VALID=0, and instruction reading r9 is accepted next cycle with no stall.
- Assert inRESET low mid-stall asynchronously -> oNEXT_VALID drops before the next edge, scoreboard=0, oSTALL_COUNT=0.
